// File: rtl/tlc_conflict_monitor.sv
// Watchdog on the four traffic lights (RED=1): decodes the registered pattern
// into a phase, checks legality, phase order and dwell time, and latches a fault code.
module tlc_conflict_monitor #(
  parameter int MIN_DWELL = 1,
  parameter int MAX_DWELL = 1,
  parameter int DWELL_W   = 4,
  parameter int COUNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               l1,
  input  logic               l2,
  input  logic               l3,
  input  logic               l4,
  input  logic               clear_fault,
  output logic [2:0]         phase,
  output logic               phase_valid,
  output logic               fault,
  output logic [1:0]         fault_code,
  output logic [COUNT_W-1:0] fault_count
);

  localparam logic [1:0] S_UNLOCKED = 2'd0;
  localparam logic [1:0] S_LOCKED   = 2'd1;
  localparam logic [1:0] S_FAULT    = 2'd2;

  localparam logic [1:0] FC_NONE    = 2'd0;
  localparam logic [1:0] FC_ILLEGAL = 2'd1;
  localparam logic [1:0] FC_SEQ     = 2'd2;
  localparam logic [1:0] FC_STUCK   = 2'd3;

  localparam logic [DWELL_W-1:0] MIN_D = DWELL_W'(MIN_DWELL);
  localparam logic [DWELL_W-1:0] MAX_D = DWELL_W'(MAX_DWELL);
  localparam logic [DWELL_W-1:0] ONE_D = DWELL_W'(1);

  logic [3:0]         r_lights;
  logic               r_primed;
  logic [1:0]         r_state;
  logic [2:0]         r_phase;
  logic [DWELL_W-1:0] r_dwell;
  logic               r_valid;
  logic               r_fault;
  logic [1:0]         r_code;
  logic [COUNT_W-1:0] r_count;

  logic               w_legal;
  logic [2:0]         w_pidx;
  logic [2:0]         w_succ;
  logic [1:0]         w_state;
  logic [2:0]         w_phase;
  logic [DWELL_W-1:0] w_dwell;
  logic [1:0]         w_code;
  logic               w_enter_fault;

  // Pattern order is {l1,l2,l3,l4}; anything not listed here is a conflict.
  always_comb begin
    w_legal = 1'b1;
    w_pidx  = 3'd0;
    case (r_lights)
      4'b0101: w_pidx = 3'd0;
      4'b1010: w_pidx = 3'd1;
      4'b0111: w_pidx = 3'd2;
      4'b1011: w_pidx = 3'd3;
      4'b1101: w_pidx = 3'd4;
      4'b1110: w_pidx = 3'd5;
      default: w_legal = 1'b0;
    endcase
  end

  assign w_succ = (r_phase == 3'd5) ? 3'd0 : r_phase + 3'd1;

  always_comb begin
    w_state       = r_state;
    w_phase       = r_phase;
    w_dwell       = r_dwell;
    w_code        = r_code;
    w_enter_fault = 1'b0;
    case (r_state)
      S_UNLOCKED: begin
        if (r_primed) begin
          if (w_legal) begin
            w_state = S_LOCKED;
            w_phase = w_pidx;
            w_dwell = ONE_D;
          end else begin
            w_enter_fault = 1'b1;
            w_code        = FC_ILLEGAL;
          end
        end
      end
      S_LOCKED: begin
        if (!w_legal) begin
          w_enter_fault = 1'b1;
          w_code        = FC_ILLEGAL;
        end else if (w_pidx == r_phase) begin
          if (r_dwell == MAX_D) begin
            w_enter_fault = 1'b1;
            w_code        = FC_STUCK;
          end else begin
            w_dwell = r_dwell + ONE_D;
          end
        end else if (w_pidx == w_succ) begin
          if (r_dwell < MIN_D) begin
            w_enter_fault = 1'b1;
            w_code        = FC_SEQ;
          end else begin
            w_phase = w_succ;
            w_dwell = ONE_D;
          end
        end else begin
          w_enter_fault = 1'b1;
          w_code        = FC_SEQ;
        end
      end
      S_FAULT: begin
        // Clearing only drops to UNLOCKED; the sample under it is not evaluated.
        if (clear_fault) begin
          w_state = S_UNLOCKED;
          w_code  = FC_NONE;
        end
      end
      default: begin
        w_state = S_UNLOCKED;
        w_phase = 3'd0;
        w_dwell = '0;
        w_code  = FC_NONE;
      end
    endcase
    if (w_enter_fault) begin
      w_state = S_FAULT;
      w_phase = 3'd0;
      w_dwell = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lights <= 4'b1111;
      r_primed <= 1'b0;
      r_state  <= S_UNLOCKED;
      r_phase  <= 3'd0;
      r_dwell  <= '0;
      r_valid  <= 1'b0;
      r_fault  <= 1'b0;
      r_code   <= FC_NONE;
      r_count  <= '0;
    end else begin
      r_lights <= {l1, l2, l3, l4};
      r_primed <= 1'b1;
      r_state  <= w_state;
      r_phase  <= w_phase;
      r_dwell  <= w_dwell;
      r_valid  <= (w_state == S_LOCKED);
      r_fault  <= (w_state == S_FAULT);
      r_code   <= w_code;
      if (w_enter_fault && (r_count != {COUNT_W{1'b1}}))
        r_count <= r_count + 1'b1;
    end
  end

  assign phase       = r_phase;
  assign phase_valid = r_valid;
  assign fault       = r_fault;
  assign fault_code  = r_code;
  assign fault_count = r_count;

endmodule

// File: tb/tb_tlc_conflict_monitor.sv
// Directed vector bench for tlc_conflict_monitor: three parameterisations
// share one stimulus bus; each sequence checks only the instance it targets.
module tb_tlc_conflict_monitor;

  logic clk = 1'b0;
  logic rst, l1, l2, l3, l4, clear_fault;

  logic [2:0] ph0, ph1, ph2;
  logic       pv0, pv1, pv2;
  logic       f0, f1, f2;
  logic [1:0] fc0, fc1, fc2;
  logic [7:0] c0, c1;
  logic [1:0] c2;

  always #5 clk = ~clk;

  tlc_conflict_monitor u_def (
    .clk(clk), .rst(rst), .l1(l1), .l2(l2), .l3(l3), .l4(l4),
    .clear_fault(clear_fault), .phase(ph0), .phase_valid(pv0),
    .fault(f0), .fault_code(fc0), .fault_count(c0));

  tlc_conflict_monitor #(.MIN_DWELL(2), .MAX_DWELL(3)) u_dwell (
    .clk(clk), .rst(rst), .l1(l1), .l2(l2), .l3(l3), .l4(l4),
    .clear_fault(clear_fault), .phase(ph1), .phase_valid(pv1),
    .fault(f1), .fault_code(fc1), .fault_count(c1));

  tlc_conflict_monitor #(.COUNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .l1(l1), .l2(l2), .l3(l3), .l4(l4),
    .clear_fault(clear_fault), .phase(ph2), .phase_valid(pv2),
    .fault(f2), .fault_code(fc2), .fault_count(c2));

  typedef struct {
    logic       rst;
    logic [3:0] l;
    logic       clr;
    logic [2:0] ph;
    logic       pv;
    logic       f;
    logic [1:0] fc;
    logic [7:0] cnt;
  } vec_t;

  vec_t q[$];
  int   errors = 0;
  int   checks = 0;

  localparam logic [3:0] P0 = 4'b0101, P1 = 4'b1010, P2 = 4'b0111;
  localparam logic [3:0] P3 = 4'b1011, P4 = 4'b1101, P5 = 4'b1110;
  logic [3:0] pat [6];

  function automatic void add(input logic r, input logic [3:0] l, input logic c,
                              input logic [2:0] ph, input logic pv, input logic f,
                              input logic [1:0] fc, input logic [7:0] cnt);
    vec_t v;
    v.rst = r; v.l = l; v.clr = c; v.ph = ph; v.pv = pv; v.f = f; v.fc = fc; v.cnt = cnt;
    q.push_back(v);
  endfunction

  function automatic void add_rst2();
    add(1'b1, P0, 1'b0, 3'd0, 1'b0, 1'b0, 2'd0, 8'd0);
    add(1'b1, P0, 1'b0, 3'd0, 1'b0, 1'b0, 2'd0, 8'd0);
  endfunction

  task automatic step(input logic r, input logic [3:0] l, input logic c);
    rst = r; {l1, l2, l3, l4} = l; clear_fault = c;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input int d, input string nm, input int idx,
                       input logic [2:0] eph, input logic epv, input logic ef,
                       input logic [1:0] efc, input logic [7:0] ecnt);
    logic [2:0] aph; logic apv, af; logic [1:0] afc; logic [7:0] acnt;
    case (d)
      0:       begin aph = ph0; apv = pv0; af = f0; afc = fc0; acnt = c0; end
      1:       begin aph = ph1; apv = pv1; af = f1; afc = fc1; acnt = c1; end
      default: begin aph = ph2; apv = pv2; af = f2; afc = fc2; acnt = {6'd0, c2}; end
    endcase
    checks++;
    if ({aph, apv, af, afc, acnt} !== {eph, epv, ef, efc, ecnt}) begin
      errors++;
      $display("FAIL %s[%0d]: got ph=%0d pv=%0b f=%0b fc=%0d cnt=%0d, want ph=%0d pv=%0b f=%0b fc=%0d cnt=%0d",
               nm, idx, aph, apv, af, afc, acnt, eph, epv, ef, efc, ecnt);
    end
  endtask

  task automatic run_q(input int d, input string nm);
    for (int i = 0; i < q.size(); i++) begin
      step(q[i].rst, q[i].l, q[i].clr);
      check(d, nm, i, q[i].ph, q[i].pv, q[i].f, q[i].fc, q[i].cnt);
    end
    q.delete();
  endtask

  initial begin
    pat[0] = P0; pat[1] = P1; pat[2] = P2; pat[3] = P3; pat[4] = P4; pat[5] = P5;
    rst = 1'b1; {l1, l2, l3, l4} = 4'b1111; clear_fault = 1'b0;

    // Lock and track on defaults: phase lags the input by one vector.
    add_rst2();
    for (int j = 0; j < 24; j++)
      add(1'b0, pat[j % 6], 1'b0, (j == 0) ? 3'd0 : 3'((j - 1) % 6), j != 0, 1'b0, 2'd0, 8'd0);
    run_q(0, "track");

    // Skip P2 after P1.
    add_rst2();
    add(0, P0, 0, 3'd0, 0, 0, 2'd0, 8'd0);
    add(0, P1, 0, 3'd0, 1, 0, 2'd0, 8'd0);
    add(0, P3, 0, 3'd1, 1, 0, 2'd0, 8'd0);
    add(0, P4, 0, 3'd0, 0, 1, 2'd2, 8'd1);
    run_q(0, "skip13");

    // Backwards jump from P2 to P0.
    add_rst2();
    add(0, P2, 0, 3'd0, 0, 0, 2'd0, 8'd0);
    add(0, P0, 0, 3'd2, 1, 0, 2'd0, 8'd0);
    add(0, P1, 0, 3'd0, 0, 1, 2'd2, 8'd1);
    run_q(0, "back20");

    // Default dwell: holding P2 for two samples is stuck.
    add_rst2();
    add(0, P1, 0, 3'd0, 0, 0, 2'd0, 8'd0);
    add(0, P2, 0, 3'd1, 1, 0, 2'd0, 8'd0);
    add(0, P2, 0, 3'd2, 1, 0, 2'd0, 8'd0);
    add(0, P3, 0, 3'd0, 0, 1, 2'd3, 8'd1);
    run_q(0, "stuck");

    // MIN=2/MAX=3: three-clock phases are legal.
    add_rst2();
    for (int j = 0; j < 21; j++)
      add(1'b0, pat[(j / 3) % 6], 1'b0, (j == 0) ? 3'd0 : 3'(((j - 1) / 3) % 6), j != 0, 1'b0, 2'd0, 8'd0);
    run_q(1, "dwell3");

    // MIN=2: one-clock phase.
    add_rst2();
    add(0, P0, 0, 3'd0, 0, 0, 2'd0, 8'd0);
    add(0, P0, 0, 3'd0, 1, 0, 2'd0, 8'd0);
    add(0, P0, 0, 3'd0, 1, 0, 2'd0, 8'd0);
    add(0, P1, 0, 3'd0, 1, 0, 2'd0, 8'd0);
    add(0, P2, 0, 3'd1, 1, 0, 2'd0, 8'd0);
    add(0, P2, 0, 3'd0, 0, 1, 2'd2, 8'd1);
    run_q(1, "short");

    // MAX=3: four-clock phase.
    add_rst2();
    add(0, P0, 0, 3'd0, 0, 0, 2'd0, 8'd0);
    add(0, P0, 0, 3'd0, 1, 0, 2'd0, 8'd0);
    add(0, P0, 0, 3'd0, 1, 0, 2'd0, 8'd0);
    add(0, P0, 0, 3'd0, 1, 0, 2'd0, 8'd0);
    add(0, P1, 0, 3'd0, 0, 1, 2'd3, 8'd1);
    run_q(1, "long");

    // 1111 through reset release, clear, clear ignored while locked, saturation.
    add(1, 4'b1111, 0, 3'd0, 0, 0, 2'd0, 8'd0);
    add(1, 4'b1111, 0, 3'd0, 0, 0, 2'd0, 8'd0);
    add(0, 4'b1111, 0, 3'd0, 0, 0, 2'd0, 8'd0);
    add(0, 4'b1111, 0, 3'd0, 0, 1, 2'd1, 8'd1);
    add(0, P0,      1, 3'd0, 0, 0, 2'd0, 8'd1);
    add(0, P1,      0, 3'd0, 1, 0, 2'd0, 8'd1);
    add(0, P2,      1, 3'd1, 1, 0, 2'd0, 8'd1);
    add(0, 4'b0000, 0, 3'd2, 1, 0, 2'd0, 8'd1);
    add(0, P4,      0, 3'd0, 0, 1, 2'd1, 8'd2);
    add(0, P0,      1, 3'd0, 0, 0, 2'd0, 8'd2);
    add(0, 4'b0000, 0, 3'd0, 1, 0, 2'd0, 8'd2);
    add(0, P1,      0, 3'd0, 0, 1, 2'd1, 8'd3);
    add(0, P0,      1, 3'd0, 0, 0, 2'd0, 8'd3);
    add(0, 4'b1111, 0, 3'd0, 1, 0, 2'd0, 8'd3);
    add(0, P0,      0, 3'd0, 0, 1, 2'd1, 8'd3);
    add(0, P0,      1, 3'd0, 0, 0, 2'd0, 8'd3);
    add(0, 4'b1111, 0, 3'd0, 1, 0, 2'd0, 8'd3);
    add(0, P0,      0, 3'd0, 0, 1, 2'd1, 8'd3);
    run_q(2, "clrsat");

    // Reset and clear together while in FAULT: reset wins, counter cleared.
    step(1'b1, P0, 1'b1);
    check(2, "rst_clr", 0, 3'd0, 1'b0, 1'b0, 2'd0, 8'd0);
    step(1'b0, P0, 1'b1);
    check(2, "rst_clr", 1, 3'd0, 1'b0, 1'b0, 2'd0, 8'd0);
    step(1'b0, P1, 1'b0);
    check(2, "rst_clr", 2, 3'd0, 1'b1, 1'b0, 2'd0, 8'd0);

    // Conflict while locked, then fault held for ten clocks of legal input.
    step(1'b1, P0, 1'b0);
    step(1'b1, P0, 1'b0);
    check(0, "conflict", 0, 3'd0, 1'b0, 1'b0, 2'd0, 8'd0);
    step(1'b0, P0, 1'b0);
    step(1'b0, P1, 1'b0);
    step(1'b0, P2, 1'b0);
    check(0, "conflict", 1, 3'd1, 1'b1, 1'b0, 2'd0, 8'd0);
    step(1'b0, 4'b0011, 1'b0);
    check(0, "conflict", 2, 3'd2, 1'b1, 1'b0, 2'd0, 8'd0);
    step(1'b0, P4, 1'b0);
    check(0, "conflict", 3, 3'd0, 1'b0, 1'b1, 2'd1, 8'd1);
    for (int k = 0; k < 10; k++) begin
      step(1'b0, pat[(k + 5) % 6], 1'b0);
      check(0, "conflict_hold", k, 3'd0, 1'b0, 1'b1, 2'd1, 8'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
